// File: rtl/inv_sub_bytes_pkg.sv
// Shared AES definitions for the inverse SubBytes block: FSM encoding and block geometry.
package inv_sub_bytes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } isb_state_e;

    localparam int BLOCK_W         = 128;
    localparam int BYTES_PER_BLOCK = 16;

endpackage

// File: rtl/inv_sbox1.sv
// Combinational FIPS-197 inverse S-box; undoes the Sbox1 byte substitution.
module inv_sbox1
    import inv_sub_bytes_pkg::*;
(
    input  logic [7:0] state,
    output logic [7:0] InvSstate
);

    // Entry 0 sits in the top byte; entry x is at bits [2047-8x -: 8].
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign InvSstate = INV_SBOX_TABLE[2047 - 8 * int'(state) -: 8];

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a captured block per cycle.
module inv_sub_bytes
    import inv_sub_bytes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] inv_state,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is 1 only in IDLE and out_valid only in DONE, so each side ignores the
    // other's valid/ready outside those states.

    localparam int GROUPS = BYTES_PER_BLOCK / BYTES_PER_CYCLE;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    isb_state_e         r_state;
    isb_state_e         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BLOCK_W-1:0] r_work;
    logic [BLOCK_W-1:0] w_work_upd;
    logic               w_last;
    int                 w_base_byte;
    logic [7:0]         w_sub_in  [BYTES_PER_CYCLE];
    logic [7:0]         w_sub_out [BYTES_PER_CYCLE];

    assign w_base_byte = (GROUPS == 1) ? 0 : int'(r_cnt) * BYTES_PER_CYCLE;
    assign w_last      = (r_cnt == LAST_CNT);

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        assign w_sub_in[g] = r_work[BLOCK_W - 1 - 8 * (w_base_byte + g) -: 8];

        inv_sbox1 u_inv_sbox1 (
            .state     (w_sub_in[g]),
            .InvSstate (w_sub_out[g])
        );
    end

    always_comb begin
        w_work_upd = r_work;
        for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
            w_work_upd[BLOCK_W - 1 - 8 * (w_base_byte + l) -: 8] = w_sub_out[l];
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The counter parks on the last group; only a fresh accept brings it back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_work <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work <= state;
                        r_cnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    r_work <= w_work_upd;
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign inv_state = r_work;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes: a 1-lane instance for most scenarios, a 16-lane one for latency.
module tb_inv_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] inv_state;
    logic [1:0]   dbg_state;

    logic         w16_in_valid;
    logic         w16_in_ready;
    logic [127:0] w16_state;
    logic         w16_out_valid;
    logic         w16_out_ready;
    logic [127:0] w16_inv_state;
    logic [1:0]   w16_dbg_state;

    int tests_run;
    int tests_failed;

    // Forward AES S-box, used to build blocks whose inverse is the byte index.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] MIXED_IN  = {4{32'h7c678416}};
    localparam logic [127:0] MIXED_EXP = {4{32'h010a4fff}};

    inv_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inv_state (inv_state),
        .dbg_state (dbg_state)
    );

    inv_sub_bytes #(.BYTES_PER_CYCLE(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w16_in_valid),
        .in_ready  (w16_in_ready),
        .state     (w16_state),
        .out_valid (w16_out_valid),
        .out_ready (w16_out_ready),
        .inv_state (w16_inv_state),
        .dbg_state (w16_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: accept blk, wait for out_valid (bounded), capture, consume.
    // lat = rising edges from the accept edge to the edge that raised out_valid.
    task automatic process_block(input logic [127:0] blk, output logic [127:0] res, output int lat);
        @(negedge clk);
        state    = blk;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = inv_state;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (inv_state !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_inv_state: got %h want 0", inv_state);
        end
        tests_run++;
        if (dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_dbg_state: got %0d want 0", dbg_state);
        end
    endtask

    task automatic test_uniform();
        logic [127:0] res;
        int lat;
        process_block({16{8'h63}}, res, lat);
        tests_run++;
        if (res !== 128'h0) begin
            tests_failed++;
            $display("FAIL uniform_result: got %h want 0", res);
        end
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL uniform_latency: got %0d want 16", lat);
        end
    endtask

    task automatic test_mixed();
        logic [127:0] res;
        int lat;
        process_block(MIXED_IN, res, lat);
        tests_run++;
        if (res !== MIXED_EXP) begin
            tests_failed++;
            $display("FAIL mixed_result: got %h want %h", res, MIXED_EXP);
        end
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL mixed_latency: got %0d want 16", lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [127:0] blk;
        logic [127:0] exp;
        logic [127:0] res;
        int lat;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                blk[127 - 8 * i -: 8] = SBOX_FWD[2047 - 8 * (16 * k + i) -: 8];
                exp[127 - 8 * i -: 8] = 8'(16 * k + i);
            end
            process_block(blk, res, lat);
            tests_run++;
            if (res !== exp) begin
                tests_failed++;
                $display("FAIL exhaustive_block%0d: got %h want %h", k, res, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int waited;
        @(negedge clk);
        state    = MIXED_IN;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_out_valid_c%0d: got %b want 1", c, out_valid);
            end
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready);
            end
            tests_run++;
            if (inv_state !== MIXED_EXP) begin
                tests_failed++;
                $display("FAIL bp_inv_state_c%0d: got %h want %h", c, inv_state, MIXED_EXP);
            end
            if (c == 2) begin
                state    = {16{8'h16}};
                in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_consume: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        tests_run++;
        if (dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL bp_idle_after: got state %0d want 0", dbg_state);
        end
    endtask

    task automatic test_reset_busy();
        logic [127:0] res;
        int lat;
        @(negedge clk);
        state    = MIXED_IN;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        tests_run++;
        if (dbg_state !== 2'd1) begin
            tests_failed++;
            $display("FAIL rb_busy_before: got state %0d want 1", dbg_state);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rb_in_ready: got %b want 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rb_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (inv_state !== 128'h0) begin
            tests_failed++;
            $display("FAIL rb_inv_state: got %h want 0", inv_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        process_block({16{8'h16}}, res, lat);
        tests_run++;
        if (res !== {16{8'hff}}) begin
            tests_failed++;
            $display("FAIL rb_next_result: got %h want all ff", res);
        end
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL rb_next_latency: got %0d want 16", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [3];
        logic [127:0] exp [3];
        int waited;
        blk[0] = {16{8'h63}};  exp[0] = 128'h0;
        blk[1] = MIXED_IN;     exp[1] = MIXED_EXP;
        blk[2] = {16{8'h16}};  exp[2] = {16{8'hff}};
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            state = blk[i];
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_accept%0d: got in_ready %b want 0", i, in_ready);
            end
            waited = 0;
            while (!out_valid && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            tests_run++;
            if (inv_state !== exp[i] || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_result%0d: got %h valid %b want %h", i, inv_state, out_valid, exp[i]);
            end
            @(negedge clk);
            if (i == 2) in_valid = 1'b0;
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_reready%0d: got in_ready %b out_valid %b want 1/0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle_end: got in_ready %b want 1", in_ready);
        end
    endtask

    task automatic test_wide_latency();
        int lat;
        @(negedge clk);
        w16_state    = MIXED_IN;
        w16_in_valid = 1'b1;
        @(negedge clk);
        w16_in_valid = 1'b0;
        lat = 0;
        while (!w16_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL wide_latency: got %0d want 1", lat);
        end
        tests_run++;
        if (w16_inv_state !== MIXED_EXP) begin
            tests_failed++;
            $display("FAIL wide_result: got %h want %h", w16_inv_state, MIXED_EXP);
        end
        w16_out_ready = 1'b1;
        @(negedge clk);
        w16_out_ready = 1'b0;
        tests_run++;
        if (w16_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wide_reready: got %b want 1", w16_in_ready);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        state         = '0;
        w16_in_valid  = 1'b0;
        w16_out_ready = 1'b0;
        w16_state     = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_uniform();
        test_mixed();
        test_exhaustive();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        test_wide_latency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes.md
INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 Parameter BYTES_PER_CYCLE, default 1, number of byte lanes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  state holds a block to accept.
REQ-005 in_ready  output  1  block can accept a new state.
REQ-006 state  input  128  input block; byte 0 = state[127:120], byte 15 = state[7:0].
REQ-007 out_valid  output  1  inv_state holds a finished result.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 inv_state  output  128  InvSubBytes(state), same byte order as state.

Function
REQ-010 The block SHALL apply the FIPS-197 inverse S-box independently to each of the 16 bytes; it is the inverse of the existing Sbox1 byte substitution.
REQ-011 FSM states SHALL be IDLE, BUSY and DONE.
REQ-012 IDLE: in_ready=1 and out_valid=0; when in_valid=1 at a clock edge, the block SHALL capture state into a 128-bit working register, clear the lane counter, and move to BUSY.
REQ-013 BUSY: in_ready=0; each cycle the block SHALL replace the bytes at counter*BYTES_PER_CYCLE through counter*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1 in place, starting at byte 0, then increment the counter.
REQ-014 After the group containing byte 15 is written, the block SHALL move to DONE; total latency is 16/BYTES_PER_CYCLE cycles from the accept edge to the edge that asserts out_valid.
REQ-015 DONE: out_valid=1, in_ready=0; inv_state SHALL be stable for as long as out_ready=0.
REQ-016 When out_ready=1 in DONE, the result SHALL be consumed at that edge and the FSM SHALL return to IDLE.
REQ-017 A new block is accepted no earlier than the cycle after consumption; in_valid is ignored outside IDLE.
REQ-018 The counter width SHALL be log2(16/BYTES_PER_CYCLE), with a minimum of 1 bit.
REQ-019 The counter SHALL wrap to 0 only via a new accept; BUSY never runs past byte 15.
REQ-020 inv_state SHALL be driven from the working register; its value outside DONE is don't-care but SHALL be deterministic.
REQ-021 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-022 rst_n=0 SHALL immediately force: FSM to IDLE, counter to 0, working register to 0, in_ready=1, out_valid=0.
REQ-023 Reset asserted during BUSY or DONE SHALL discard the block in flight with no partial output.
REQ-024 The first accept after rst_n deasserts SHALL behave exactly as from power-up.

Structure
REQ-025 The shared AES package SHALL hold the FSM state encoding, the block width constant (128), and the bytes-per-block constant (16).
REQ-026 One sub-module, inv_sbox1, SHALL implement the combinational 8-bit inverse S-box and be instantiated BYTES_PER_CYCLE times.
REQ-027 inv_sbox1 ports SHALL mirror Sbox1: an 8-bit state input and an 8-bit InvSstate output.

Verification
REQ-028 Exhaustive check: for x = 0x00..0xFF, inv_sbox1(Sbox1(x)) == x; spot values 7c->01, 67->0a, 84->4f, 63->00, 16->ff.
REQ-029 Uniform block: state = {16{8'h63}} -> inv_state = 128'h0; out_valid rises exactly 16 cycles after accept with BYTES_PER_CYCLE=1, and 1 cycle after accept with BYTES_PER_CYCLE=16.
REQ-030 Mixed block: state = 7c6784631 6 pattern repeated, i.e. {4{32'h7c678463}} with byte 3 of each word set to 16 -> each byte inverted per REQ-028; byte order is preserved.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, inv_state is unchanged, in_ready stays 0, and an in_valid pulse is ignored.
REQ-032 Reset mid-BUSY: assert rst_n=0 at counter=7 -> outputs immediately show in_ready=1 and out_valid=0; the next block {16{8'h16}} yields {16{8'hff}}.
REQ-033 Back-to-back operation: assert out_ready=1 and in_valid=1 continuously -> each block completes; the accept follows consumption by exactly 1 cycle.
